// File: rtl/satd_pkg.sv
// Shared definitions for the SATD block controller.
//   satd_state_e : controller FSM states (IDLE / PASS0 / PASS1 / DONE)
//   groups_of()  : coefficient groups of 16 per WIDTH x HEIGHT block
//   acc_width()  : accumulator width that cannot overflow for a block
package satd_pkg;

  localparam int GROUP_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS0 = 2'd1,
    ST_PASS1 = 2'd2,
    ST_DONE  = 2'd3
  } satd_state_e;

  function automatic int groups_of(input int width, input int height);
    return (width * height) / GROUP_SIZE;
  endfunction

  // Each pass sum is LENGTH+8 bits and a block contributes 2*GROUPS of them.
  function automatic int acc_width(input int length, input int groups);
    return length + 8 + $clog2(2 * groups);
  endfunction

endpackage

// File: rtl/block_htv_absum.sv
// Combinational vertical Hadamard + absolute sum over half a coefficient group.
//   i_bank : 16 signed coefficients, coefficient k at bits [k*(LENGTH+1) +: LENGTH+1]
//   i_sel  : 0 -> coefficients 0..7, 1 -> coefficients 8..15
//   o_sum  : sum of |H8 * x| over the selected 8 coefficients (unsigned, LENGTH+8 bits)
module block_htv_absum #(
  parameter int LENGTH = 11,
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic [16*(LENGTH+1)-1:0] i_bank,
  input  logic                     i_sel,
  output logic [LENGTH+7:0]        o_sum
);

  localparam int CW = LENGTH + 1;  // coefficient width
  localparam int TW = LENGTH + 4;  // 8-point transform growth: 3 bits
  localparam int SW = LENGTH + 8;  // pass sum width

  if (WIDTH * HEIGHT >= 16) begin : g_dp
    logic signed [TW-1:0] w_x [8];
    logic signed [TW-1:0] w_a [8];
    logic signed [TW-1:0] w_b [8];
    logic signed [TW-1:0] w_c [8];
    logic        [TW-1:0] w_mag [8];
    logic        [SW-1:0] w_acc;

    always_comb begin
      for (int i = 0; i < 8; i++) begin
        w_x[i] = TW'($signed(i_bank[(i + (i_sel ? 8 : 0)) * CW +: CW]));
      end
      // Radix-2 butterflies, strides 4, 2, 1.
      for (int i = 0; i < 4; i++) begin
        w_a[i]     = w_x[i] + w_x[i+4];
        w_a[i+4]   = w_x[i] - w_x[i+4];
      end
      for (int g = 0; g < 8; g += 4) begin
        for (int i = 0; i < 2; i++) begin
          w_b[g+i]   = w_a[g+i] + w_a[g+i+2];
          w_b[g+i+2] = w_a[g+i] - w_a[g+i+2];
        end
      end
      for (int i = 0; i < 8; i += 2) begin
        w_c[i]   = w_b[i] + w_b[i+1];
        w_c[i+1] = w_b[i] - w_b[i+1];
      end
      // The most negative value negates to itself, which read unsigned is
      // exactly its magnitude, so no extra bit is needed.
      w_acc = '0;
      for (int i = 0; i < 8; i++) begin
        w_mag[i] = w_c[i][TW-1] ? -w_c[i] : w_c[i];
        w_acc    = w_acc + SW'(w_mag[i]);
      end
    end

    assign o_sum = w_acc;
  end else begin : g_no_dp
    assign o_sum = '0;
  end

endmodule

// File: rtl/satd_block_ctrl.sv
// Sequencing controller for the vertical Hadamard / absolute-sum datapath.
// Captures one group of 16 coefficients per input handshake, runs the shared
// datapath twice per group (sel=0 then sel=1), accumulates over all groups of a
// WIDTH x HEIGHT block and presents the block SATD on a valid/ready output.
//   clk, rst          : clock, synchronous active-high reset
//   flush             : synchronous abort of the current block
//   in_valid/in_ready : coefficient group handshake, hth_0..hth_15 signed
//   out_valid/out_ready, satd : block result handshake
//   busy              : block in progress
//   o_dbg_state       : current FSM state (satd_state_e encoding)
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is a decode of registered state only; out_valid and satd stay
// constant until out_ready, except when rst or flush drops them.
module satd_block_ctrl
  import satd_pkg::*;
#(
  parameter  int LENGTH = 11,
  parameter  int WIDTH  = 8,
  parameter  int HEIGHT = 8,
  localparam int GROUPS = groups_of(WIDTH, HEIGHT),
  localparam int ACC_W  = acc_width(LENGTH, GROUPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [LENGTH:0]   hth_0,
  input  logic signed [LENGTH:0]   hth_1,
  input  logic signed [LENGTH:0]   hth_2,
  input  logic signed [LENGTH:0]   hth_3,
  input  logic signed [LENGTH:0]   hth_4,
  input  logic signed [LENGTH:0]   hth_5,
  input  logic signed [LENGTH:0]   hth_6,
  input  logic signed [LENGTH:0]   hth_7,
  input  logic signed [LENGTH:0]   hth_8,
  input  logic signed [LENGTH:0]   hth_9,
  input  logic signed [LENGTH:0]   hth_10,
  input  logic signed [LENGTH:0]   hth_11,
  input  logic signed [LENGTH:0]   hth_12,
  input  logic signed [LENGTH:0]   hth_13,
  input  logic signed [LENGTH:0]   hth_14,
  input  logic signed [LENGTH:0]   hth_15,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         satd,
  output logic                     busy,
  output logic [1:0]               o_dbg_state
);

  localparam int CW    = LENGTH + 1;
  localparam int SW    = LENGTH + 8;
  localparam int CNT_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

  satd_state_e        r_state;
  logic [CNT_W-1:0]   r_grp_cnt;
  logic [16*CW-1:0]   r_bank;
  logic [ACC_W-1:0]   r_acc;
  logic               r_in_ready;
  logic               r_out_valid;

  logic [16*CW-1:0]   w_live;
  logic               w_sel;
  logic [SW-1:0]      w_sum;
  logic [ACC_W-1:0]   w_sum_ext;
  logic               w_capture;
  logic               w_last;

  assign w_live = {hth_15, hth_14, hth_13, hth_12, hth_11, hth_10, hth_9, hth_8,
                   hth_7,  hth_6,  hth_5,  hth_4,  hth_3,  hth_2,  hth_1, hth_0};

  assign w_sel     = (r_state == ST_PASS1);
  assign w_sum_ext = ACC_W'(w_sum);
  assign w_capture = in_valid && r_in_ready;
  assign w_last    = (r_grp_cnt == LAST_GRP);

  block_htv_absum #(
    .LENGTH (LENGTH),
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_htv_absum (
    .i_bank (r_bank),
    .i_sel  (w_sel),
    .o_sum  (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grp_cnt   <= '0;
      r_bank      <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      // Any capture offered in the same cycle is discarded.
      r_state     <= ST_IDLE;
      r_grp_cnt   <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            r_bank     <= w_live;
            r_state    <= ST_PASS0;
            r_in_ready <= 1'b0;
          end
        end
        ST_PASS0: begin
          r_acc      <= r_acc + w_sum_ext;
          r_state    <= ST_PASS1;
          // PASS1 of the last group must not accept the next block's data.
          r_in_ready <= !w_last;
        end
        ST_PASS1: begin
          r_acc <= r_acc + w_sum_ext;
          if (w_last) begin
            r_grp_cnt   <= '0;
            r_state     <= ST_DONE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_grp_cnt <= r_grp_cnt + 1'b1;
            // The PASS1 read of the bank completes this cycle, so the next
            // group may overwrite it at this same edge.
            if (w_capture) begin
              r_bank     <= w_live;
              r_state    <= ST_PASS0;
              r_in_ready <= 1'b0;
            end else begin
              r_state    <= ST_IDLE;
              r_in_ready <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_acc       <= '0;
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign satd        = r_acc;
  assign busy        = (r_grp_cnt != '0) || (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_satd_block_ctrl.sv
module tb_satd_block_ctrl;

  localparam int LENGTH = 11;
  localparam int ACC_W  = 22;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [LENGTH:0]   hth [16];
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  satd;
  logic              busy;
  logic [1:0]        dbg_state;

  logic [LENGTH:0]   blk [4][16];
  logic [ACC_W-1:0]  exp_q [$];
  logic [ACC_W-1:0]  exp_v;
  logic [8:0]        rdy_pat;

  int n_vec;
  int n_err;

  satd_block_ctrl #(
    .LENGTH (LENGTH),
    .WIDTH  (8),
    .HEIGHT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .hth_0       (hth[0]),
    .hth_1       (hth[1]),
    .hth_2       (hth[2]),
    .hth_3       (hth[3]),
    .hth_4       (hth[4]),
    .hth_5       (hth[5]),
    .hth_6       (hth[6]),
    .hth_7       (hth[7]),
    .hth_8       (hth[8]),
    .hth_9       (hth[9]),
    .hth_10      (hth[10]),
    .hth_11      (hth[11]),
    .hth_12      (hth[12]),
    .hth_13      (hth[13]),
    .hth_14      (hth[14]),
    .hth_15      (hth[15]),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .satd        (satd),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Comparison point
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Golden model: explicit 8x8 Hadamard matrix, sign = parity(k & j).
  function automatic int model_group(input int g);
    int tot, s, x;
    tot = 0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 8; k++) begin
        s = 0;
        for (int j = 0; j < 8; j++) begin
          x = int'($signed(blk[g][p*8+j]));
          if (($countones(k & j) % 2) == 1) s -= x;
          else s += x;
        end
        tot += (s < 0) ? -s : s;
      end
    end
    return tot;
  endfunction

  function automatic logic [ACC_W-1:0] model_block();
    int t;
    t = 0;
    for (int g = 0; g < 4; g++) t += model_group(g);
    return ACC_W'(t);
  endfunction

  // Drivers
  task automatic load_const(input logic [LENGTH:0] v);
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 16; i++) blk[g][i] = v;
  endtask

  task automatic load_random();
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 16; i++) blk[g][i] = 12'($urandom_range(0, 4095));
  endtask

  task automatic send_group(input int g);
    for (int i = 0; i < 16; i++) hth[i] = blk[g][i];
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !in_ready; k++) @(negedge clk);
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_block(input int gap);
    for (int g = 0; g < 4; g++) begin
      repeat (gap) @(negedge clk);
      send_group(g);
    end
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 60 && !out_valid; k++) @(negedge clk);
    check("out_valid_rise", 32'(out_valid), 32'd1);
  endtask

  task automatic take_result(input string tag);
    exp_v = exp_q.pop_front();
    check(tag, 32'(satd), 32'(exp_v));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("idle_after_hs", 32'(dbg_state), 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) hth[i] = '0;

    // Reset state
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_satd", 32'(satd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // 1: all-zero groups, source always valid, sink always ready
    rdy_pat   = 9'b001010101;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      check($sformatf("t1_in_ready_c%0d", c), 32'(in_ready), 32'(rdy_pat[c]));
      check($sformatf("t1_no_valid_c%0d", c), 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    check("t1_out_valid_at_8", 32'(out_valid), 32'd1);
    check("t1_satd", 32'(satd), 32'd0);
    check("t1_in_ready_done", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("t1_out_valid_drop", 32'(out_valid), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: random coefficients against the matrix model
    load_random();
    exp_q.push_back(model_block());
    run_block(0);
    wait_valid();
    take_result("t2_satd_random");

    // 3 + 4: magnitude extreme -2048 everywhere, 4*2*16384 = 131072
    load_const(12'h800);
    exp_q.push_back(22'd131072);
    run_block(0);
    wait_valid();
    exp_v = exp_q.pop_front();
    in_valid = 1'b1;
    for (int s = 0; s < 5; s++) begin
      check($sformatf("t4_satd_hold_%0d", s), 32'(satd), 32'(exp_v));
      check($sformatf("t4_valid_hold_%0d", s), 32'(out_valid), 32'd1);
      check($sformatf("t4_in_ready_%0d", s), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t4_state_idle", 32'(dbg_state), 32'd0);
    check("t4_acc_clear", 32'(satd), 32'd0);
    check("t4_valid_drop", 32'(out_valid), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);

    // 5: flush in PASS1 of group 2 with a simultaneous offer
    load_random();
    send_group(0);
    send_group(1);
    send_group(2);
    @(negedge clk);
    check("t5_in_pass1", 32'(dbg_state), 32'd2);
    for (int i = 0; i < 16; i++) hth[i] = blk[3][i];
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("t5_state_idle", 32'(dbg_state), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_satd_clear", 32'(satd), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("t5_no_capture", 32'(dbg_state), 32'd0);
    load_random();
    exp_q.push_back(model_block());
    run_block(0);
    wait_valid();
    take_result("t5_satd_after_flush");

    // 6: 3-cycle gaps, hand-computed block:
    //    g0 hth_0=100 -> 800, g1 hth_8=-2048 -> 16384, g2 zero, g3 all 2047 -> 32752
    load_const(12'd0);
    blk[0][0] = 12'd100;
    blk[1][8] = 12'h800;
    for (int i = 0; i < 16; i++) blk[3][i] = 12'd2047;
    exp_q.push_back(22'd49936);
    run_block(3);
    wait_valid();
    take_result("t6_satd_gaps");

    // 6: reset while holding a result in DONE
    load_const(12'h800);
    run_block(0);
    wait_valid();
    check("t6_satd_before_rst", 32'(satd), 32'd131072);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd1);
    check("t6_rst_satd", 32'(satd), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
